w_port_alloc_ctrl: RTL

//  Wormhole output-port allocator and flow controller for the router's WEST output.

---
 rtl/noc_pkg.sv | 37 +++
 rtl/rr_pick4.sv | 34 +++
 rtl/w_port_alloc_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared router types, port indices and crossbar select helpers
package noc_pkg;

    // Requester bit positions in the 4-bit request/grant vectors
    localparam int IDX_N = 3;
    localparam int IDX_S = 2;
    localparam int IDX_E = 1;
    localparam int IDX_L = 0;

    // Crossbar select encodings; W is listed for completeness but never
    // produced by the WEST allocator (no U-turns)
    typedef enum logic [2:0] {
        CS_N    = 3'b000,
        CS_S    = 3'b001,
        CS_W    = 3'b010,
        CS_E    = 3'b011,
        CS_L    = 3'b100,
        CS_NONE = 3'b111
    } cs_sel_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } alloc_state_t;

    // Map a one-hot requester vector onto the crossbar select code
    function automatic cs_sel_t onehot_to_cs(input logic [3:0] oh);
        cs_sel_t cs;
        cs = CS_NONE;
        if (oh == (4'b0001 << IDX_N)) cs = CS_N;
        else if (oh == (4'b0001 << IDX_S)) cs = CS_S;
        else if (oh == (4'b0001 << IDX_E)) cs = CS_E;
        else if (oh == (4'b0001 << IDX_L)) cs = CS_L;
        return cs;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational rotating-priority pick over four requesters
module rr_pick4 (
    input  logic [3:0] ptr_i,
    input  logic [3:0] req_i,
    output logic [3:0] gnt_o
);

    logic [1:0] start_idx;
    logic [1:0] idx;
    logic       found;

    // Search downward from the one-hot priority pointer, wrapping 0 -> 3
    always_comb begin
        start_idx = 2'd3;
        idx       = 2'd0;
        found     = 1'b0;
        gnt_o     = 4'b0000;
        case (ptr_i)
            4'b1000: start_idx = 2'd3;
            4'b0100: start_idx = 2'd2;
            4'b0010: start_idx = 2'd1;
            4'b0001: start_idx = 2'd0;
            default: start_idx = 2'd3;
        endcase
        for (int k = 0; k < 4; k++) begin
            idx = start_idx - k[1:0];
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/w_port_alloc_ctrl.sv
// rtl/w_port_alloc_ctrl.sv - WEST output wormhole allocator with credit flow control
module w_port_alloc_ctrl #(
    parameter int CREDIT_DEPTH = 4,
    parameter int CNT_W        = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req_valid_i,
    input  logic [3:0]       req_head_i,
    input  logic [3:0]       req_tail_i,
    input  logic             credit_return_i,
    output logic [3:0]       grant_o,
    output logic [2:0]       cs_sel_o,
    output logic             flit_xfer_o,
    output logic             change_order_o,
    output logic [CNT_W-1:0] credit_cnt_o,
    output logic             busy_o
);

    import noc_pkg::*;

    localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(CREDIT_DEPTH);
    localparam logic [CNT_W-1:0] CREDIT_ONE = CNT_W'(1);
    localparam logic [3:0]       PTR_RESET  = 4'b1000;

    alloc_state_t     state_q,  state_d;
    logic [3:0]       grant_q,  grant_d;
    cs_sel_t          cs_q,     cs_d;
    logic [3:0]       ptr_q,    ptr_d;
    logic [CNT_W-1:0] credit_q, credit_d;

    logic [3:0] elig;
    logic [3:0] pick;
    logic       xfer;
    logic       tail_xfer;

    // Only head flits may open a new packet
    assign elig = req_valid_i & req_head_i;

    rr_pick4 u_pick (
        .ptr_i (ptr_q),
        .req_i (elig),
        .gnt_o (pick)
    );

    // A flit moves when the locked requester presents one and downstream has room
    assign xfer      = (state_q == LOCKED) && (|(req_valid_i & grant_q)) && (credit_q != '0);
    assign tail_xfer = xfer && (|(req_tail_i & grant_q));

    // Allocation FSM next state: lock on a head, release on the tail transfer
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cs_d    = cs_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|elig) begin
                    state_d = LOCKED;
                    grant_d = pick;
                    cs_d    = onehot_to_cs(pick);
                end
            end
            LOCKED: begin
                if (tail_xfer) begin
                    state_d = IDLE;
                    grant_d = 4'b0000;
                    cs_d    = CS_NONE;
                    // finished requester drops to lowest priority
                    ptr_d   = {grant_q[0], grant_q[3:1]};
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
                cs_d    = CS_NONE;
            end
        endcase
    end

    // Credit counter: a send and a return in the same cycle cancel out
    always_comb begin
        credit_d = credit_q;
        if (xfer && !credit_return_i) begin
            credit_d = credit_q - CREDIT_ONE;
        end else if (!xfer && credit_return_i && (credit_q != CREDIT_MAX)) begin
            credit_d = credit_q + CREDIT_ONE;
        end
    end

    // State registers; reset aborts any packet in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            grant_q  <= 4'b0000;
            cs_q     <= CS_NONE;
            ptr_q    <= PTR_RESET;
            credit_q <= CREDIT_MAX;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            cs_q     <= cs_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
        end
    end

    assign grant_o        = grant_q;
    assign cs_sel_o       = cs_q;
    assign flit_xfer_o    = xfer;
    assign change_order_o = tail_xfer;
    assign credit_cnt_o   = credit_q;
    assign busy_o         = (state_q == LOCKED);

endmodule
